// File: rtl/cpu_defs_pkg.sv
// Shared pipeline definitions: forward-select codes, Tnew/Tuse type and register constants.
package cpu_defs_pkg;

  typedef logic [1:0] tnew_t;
  typedef logic [4:0] regAddr_t;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam regAddr_t REG_ZERO = 5'd0;

  // One stage closer to write-back; a ready result stays ready.
  function automatic tnew_t tnewDec(tnew_t t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/hazard_src_check.sv
// Per-operand check: picks the nearest producing stage and flags a stall
// when that producer's result arrives later than this operand is consumed.
module hazard_src_check
  import cpu_defs_pkg::*;
(
  input  logic [4:0] src,
  input  logic [1:0] tuse,
  input  logic [4:0] eDst,
  input  logic [1:0] eTnew,
  input  logic       eWe,
  input  logic [4:0] mDst,
  input  logic [1:0] mTnew,
  input  logic       mWe,
  input  logic [4:0] wDst,
  input  logic       wWe,
  output logic [1:0] sel,
  output logic       stallI
);

  // Only the youngest match matters; older writers of the same register are stale.
  always_comb begin
    sel    = FWD_RF;
    stallI = 1'b0;
    if (src != REG_ZERO) begin
      if (eWe && (eDst == src)) begin
        sel    = FWD_E;
        stallI = (eTnew > tuse);
      end else if (mWe && (mDst == src)) begin
        sel    = FWD_M;
        stallI = (mTnew > tuse);
      end else if (wWe && (wDst == src)) begin
        sel    = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_tuse.sv
// D-stage hazard/forwarding controller: shadow E/M/W pipeline, per-operand
// Tuse/Tnew checks and a mult/div busy counter that stalls HI/LO users.
module hazard_ctrl_tuse
  import cpu_defs_pkg::*;
#(
  parameter int NSRC        = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [NSRC*5-1:0] d_src,
  input  logic [NSRC*2-1:0] d_tuse,
  input  logic [4:0]        d_dst,
  input  logic              d_regwrite,
  input  logic [1:0]        d_tnew,
  input  logic              d_md_start,
  input  logic              d_md_div,
  input  logic              d_md_use,
  output logic              stall,
  output logic [NSRC*2-1:0] fwd_sel,
  output logic              md_busy
);

  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  logic [4:0]    eDstReg, mDstReg, wDstReg;
  tnew_t         eTnewReg, mTnewReg;
  logic          eWeReg, mWeReg, wWeReg;
  logic          eMdReg, eDivReg;
  logic [CW-1:0] mdCntReg;

  logic [NSRC*2-1:0] srcSel;
  logic [NSRC-1:0]   srcStall;
  logic              mdStall;
  logic              issue;

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      hazard_src_check u_check (
        .src    (d_src[5*gi +: 5]),
        .tuse   (d_tuse[2*gi +: 2]),
        .eDst   (eDstReg),
        .eTnew  (eTnewReg),
        .eWe    (eWeReg),
        .mDst   (mDstReg),
        .mTnew  (mTnewReg),
        .mWe    (mWeReg),
        .wDst   (wDstReg),
        .wWe    (wWeReg),
        .sel    (srcSel[2*gi +: 2]),
        .stallI (srcStall[gi])
      );
    end
  endgenerate

  assign md_busy = eMdReg | (mdCntReg != '0);
  assign mdStall = d_valid & d_md_use & md_busy;
  assign stall   = d_valid & ((|srcStall) | mdStall);
  assign fwd_sel = d_valid ? srcSel : '0;
  assign issue   = d_valid & ~stall;

  // Downstream of D never stalls, so the shadow stages advance every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eDstReg  <= REG_ZERO;
      eTnewReg <= 2'd0;
      eWeReg   <= 1'b0;
      eMdReg   <= 1'b0;
      eDivReg  <= 1'b0;
      mDstReg  <= REG_ZERO;
      mTnewReg <= 2'd0;
      mWeReg   <= 1'b0;
      wDstReg  <= REG_ZERO;
      wWeReg   <= 1'b0;
    end else begin
      eDstReg  <= issue ? d_dst : REG_ZERO;
      eTnewReg <= issue ? d_tnew : 2'd0;
      eWeReg   <= issue & d_regwrite;
      eMdReg   <= issue & d_md_start;
      eDivReg  <= issue & d_md_start & d_md_div;
      mDstReg  <= eDstReg;
      mTnewReg <= tnewDec(eTnewReg);
      mWeReg   <= eWeReg;
      wDstReg  <= mDstReg;
      wWeReg   <= mWeReg;
    end
  end

  // Busy window starts when the md op leaves E and keeps counting through stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdCntReg <= '0;
    end else if (eMdReg) begin
      mdCntReg <= eDivReg ? DIV_LOAD : MULT_LOAD;
    end else if (mdCntReg != '0) begin
      mdCntReg <= mdCntReg - 1'b1;
    end
  end

endmodule
